// File: rtl/seq_shifter.sv
// Multi-cycle log-step shifter: SLL / SRA / ROR over SHW iterations, one shift-amount bit per clock.
// start/busy/done handshake; out holds the last completed result.
module seq_shifter #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    input  logic [SHW-1:0]   shift,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done
);

    localparam int CW = (SHW > 1) ? $clog2(SHW) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, next_state;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] stage_val;
    logic [WIDTH-1:0] out_q;
    logic [SHW-1:0]   shift_q;
    logic [1:0]       mode_q;
    logic [CW-1:0]    cnt;
    logic [SHW:0]     amt;
    logic             last;
    logic             accept;

    assign last   = (cnt == CW'(SHW - 1));
    assign accept = start && (state != RUN);
    assign amt    = (SHW + 1)'(1) << cnt;

    // One stage of the log shifter: distance 2**cnt, applied only if that shift bit is set.
    always_comb begin
        stage_val = work;
        if (shift_q[cnt]) begin
            case (mode_q)
                2'b01:   stage_val = $signed(work) >>> amt;
                2'b10:   stage_val = (work >> amt) | (work << (WIDTH - amt));
                default: stage_val = work << amt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (last) next_state = DONE;
            DONE:    next_state = start ? RUN : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
        out  = out_q;
    end

    // out is loaded on the final RUN edge so it is already valid in the DONE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work    <= '0;
            out_q   <= '0;
            shift_q <= '0;
            mode_q  <= '0;
            cnt     <= '0;
        end else if (state == RUN) begin
            work <= stage_val;
            if (last) begin
                out_q <= stage_val;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else if (accept) begin
            work    <= in;
            shift_q <= shift;
            mode_q  <= mode;
            cnt     <= '0;
        end
    end

endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter: latency, each mode, aliasing, busy-ignore, back-to-back and mid-run reset.
module tb_seq_shifter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] in;
    logic [3:0]  shift;
    logic [1:0]  mode;
    logic [15:0] out;
    logic        busy;
    logic        done;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] prev   = 16'h0000;

    seq_shifter #(.WIDTH(16), .SHW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .in    (in),
        .shift (shift),
        .mode  (mode),
        .out   (out),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Full operation from IDLE; out must hold the previous result during RUN.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [3:0] s,
                          input logic [1:0] m, input logic [15:0] exp);
        @(negedge clk);
        check({tag, "_idle_done"}, {15'd0, done}, 16'd0);
        in = a; shift = s; mode = m; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in = 16'h5A5A; shift = 4'hF; mode = 2'b10;
        check({tag, "_busy0"}, {15'd0, busy}, 16'd1);
        check({tag, "_hold"}, out, prev);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("%s_busy%0d", tag, i), {14'd0, busy, done}, 16'd2);
        end
        @(negedge clk);
        check({tag, "_done"}, {14'd0, busy, done}, 16'd1);
        check({tag, "_out"}, out, exp);
        prev = exp;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; in = '0; shift = '0; mode = '0;
        repeat (2) @(negedge clk);
        check("reset_out", out, 16'h0000);
        check("reset_flags", {14'd0, busy, done}, 16'd0);
        rst_n = 1'b1;

        run_op("sll15",    16'h0001, 4'd15, 2'b00, 16'h8000);
        run_op("sra_neg",  16'h8000, 4'd4,  2'b01, 16'hF800);
        run_op("sra_pos",  16'h7FF0, 4'd4,  2'b01, 16'h07FF);
        run_op("ror4",     16'h1234, 4'd4,  2'b10, 16'h4123);
        run_op("ror1",     16'h0001, 4'd1,  2'b10, 16'h8000);
        run_op("mode11",   16'h00FF, 4'd8,  2'b11, 16'hFF00);
        run_op("shift0",   16'hABCD, 4'd0,  2'b01, 16'hABCD);
        run_op("sra15",    16'h8000, 4'd15, 2'b01, 16'hFFFF);

        // start during RUN ignored; start in DONE cycle accepted back-to-back
        @(negedge clk);
        in = 16'h0003; shift = 4'd2; mode = 2'b00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy0", {15'd0, busy}, 16'd1);
        @(negedge clk);
        in = 16'hFFFF; shift = 4'd1; mode = 2'b00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b_ignored_busy", {14'd0, busy, done}, 16'd2);
        @(negedge clk);
        check("b2b_busy3", {14'd0, busy, done}, 16'd2);
        @(negedge clk);
        check("b2b_done1", {14'd0, busy, done}, 16'd1);
        check("b2b_out1", out, 16'h000C);
        in = 16'h0010; shift = 4'd4; mode = 2'b10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b_rerun_busy", {14'd0, busy, done}, 16'd2);
        check("b2b_rerun_hold", out, 16'h000C);
        repeat (3) @(negedge clk);
        check("b2b_rerun_busy3", {14'd0, busy, done}, 16'd2);
        @(negedge clk);
        check("b2b_done2", {14'd0, busy, done}, 16'd1);
        check("b2b_out2", out, 16'h0001);

        // reset in the second RUN cycle aborts the operation
        @(negedge clk);
        in = 16'h8000; shift = 4'd15; mode = 2'b01; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_out", out, 16'h0000);
        check("abort_flags", {14'd0, busy, done}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("abort_nodone%0d", i), {14'd0, busy, done}, 16'd0);
        end
        prev = 16'h0000;
        run_op("post_reset", 16'h0002, 4'd3, 2'b00, 16'h0010);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/seq_shifter.md
Name: seq_shifter

Overview:
Multi-cycle, log-step shift unit for the 16-bit datapath. Implements the same operations as the combinational shifter: SLL, SRA and ROR, with mode 11 aliased to SLL. Processes one shift-amount bit per clock, so it takes 4 cycles per operation. Uses a start/busy/done handshake and is the drop-in alternative wherever a shift can be spread over several cycles to relieve the critical path.

Parameters:
WIDTH, 16, data width; must equal 2**SHW
SHW, 4, shift-amount width; also the number of iteration cycles

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when busy=0
in  input  WIDTH  operand, captured on an accepted start
shift  input  SHW  shift amount, captured on an accepted start
mode  input  2  00 SLL, 01 SRA, 10 ROR, 11 SLL; captured on an accepted start
out  output  WIDTH  result register; holds the last completed result
busy  output  1  high while an operation is in flight
done  output  1  single-cycle pulse when out is updated

Behaviour:
- Reset: asynchronous, effective immediately while rst_n=0.
  - All outputs and internal registers reset to 0: out=0x0000, busy=0, done=0, state=IDLE, step counter=0.
- States:
  - IDLE: busy=0. On start=1: capture in/shift/mode into working registers, counter=0, go to RUN.
  - RUN: busy=1. Each cycle applies stage k = counter.
    - If captured shift[k]=1, shift the working value by 2**k per mode; otherwise pass it through.
    - Counter increments. After stage SHW-1, go to DONE.
  - DONE: busy=0, done=1 for exactly one cycle, out <= working value.
    - start=1 in this cycle is accepted (back-to-back): capture and go to RUN.
    - Otherwise go to IDLE.
- Latency: start sampled at edge E, stages applied at edges E+1..E+4.
  - out is valid and done=1 in the cycle after edge E+4.
  - Fixed for every shift amount, including 0.
  - Throughput: one result per 5 cycles.
- Stage arithmetic at step 2**k:
  - SLL: fill with zeros.
  - SRA: fill with the captured bit[WIDTH-1], replicated at every stage.
  - ROR: bits leaving the LSB re-enter at the MSB.
- Mode 11 is treated identically to 00.
- start while busy=1 is ignored; captured operands are unaffected. Changes to in/shift/mode during RUN have no effect.
- out changes only on the DONE transition. It holds the previous result throughout RUN and is never an intermediate value.
- shift=0 in any mode: out = captured in.
- Reset asserted mid-RUN: operation aborted, out=0, no done pulse. After release, the next start runs normally.
- done and busy are never high in the same cycle.

Test Plan:
1. Reset, then start with in=0x0001, shift=15, mode=00 -> busy=1 for 4 cycles, then done=1 with out=0x8000 in the next cycle.
2. in=0x8000, shift=4, mode=01 -> out=0xF800. Then in=0x7FF0, shift=4, mode=01 -> out=0x07FF.
3. in=0x1234, shift=4, mode=10 -> out=0x4123. Then in=0x0001, shift=1, mode=10 -> out=0x8000.
4. in=0x00FF, shift=8, mode=11 -> out=0xFF00. Then in=0xABCD, shift=0, mode=01 -> out=0xABCD, still with 4-cycle latency.
5. Start SLL 0x0003 by 2. Pulse start with 0xFFFF by 1 two cycles later -> second start ignored, out=0x000C. Start asserted in the DONE cycle with 0x0010, ROR by 4 -> accepted, next done gives out=0x0001.
6. Start SRA 0x8000 by 15, drop rst_n during the 2nd RUN cycle -> out=0, busy=0, done never pulses. After release, start 0x0002 SLL 3 -> out=0x0010.
